input_conditioner: RTL and testbench

- Front-end for the coprocessor control path; sits directly upstream of the main Controller FSM.
- Takes raw active-low push-buttons (return, zoom-in, zoom-out) and the four algorithm switches.
- Produces synchronized, debounced, single-cycle command pulses plus a validated algorithm selection and the switch error flags.
- Replaces the bare edge detectors in the top level. KEY[0] remains the system reset and is not handled here.

---
 rtl/input_conditioner_pkg.sv | 44 ++++
 rtl/input_conditioner_debounce_fsm.sv | 107 ++++++++++
 rtl/input_conditioner.sv | 134 +++++++++++++
 tb/tb_input_conditioner.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the input conditioner.
//   - key_state_e : per-key debounce FSM state encoding
//   - KEY_*       : bit positions of the buttons in key_n
//   - ALG_*       : algorithm select codes
//   - encode_alg / multi_hot : decode helpers for the stable switch vector
package input_conditioner_pkg;

  localparam int unsigned NUM_KEYS = 3;
  localparam int unsigned NUM_SW   = 4;
  localparam int unsigned ALG_W    = 2;

  localparam int unsigned KEY_RETURN   = 0;
  localparam int unsigned KEY_ZOOM_IN  = 1;
  localparam int unsigned KEY_ZOOM_OUT = 2;

  localparam logic [ALG_W-1:0] ALG_0 = 2'b00;
  localparam logic [ALG_W-1:0] ALG_1 = 2'b01;
  localparam logic [ALG_W-1:0] ALG_2 = 2'b10;
  localparam logic [ALG_W-1:0] ALG_3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } key_state_e;

  // Lowest set switch wins; an all-zero vector maps to ALG_0.
  function automatic logic [ALG_W-1:0] encode_alg(input logic [NUM_SW-1:0] v);
    logic [ALG_W-1:0] code;
    code = ALG_0;
    if (v[0])      code = ALG_0;
    else if (v[1]) code = ALG_1;
    else if (v[2]) code = ALG_2;
    else if (v[3]) code = ALG_3;
    return code;
  endfunction

  // More than one switch high.
  function automatic logic multi_hot(input logic [NUM_SW-1:0] v);
    return ($countones(v) > 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_fsm.sv
// Single push-button conditioner: 2-flop synchronizer, inversion to a
// pressed level, and a four-state debounce FSM with a dwell counter.
// Ports:
//   clk      - system clock
//   reset    - asynchronous active-high reset
//   key_n_i  - raw active-low button
//   req_o    - registered one-cycle request on an accepted press
module debounce_fsm
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic req_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_q;
  logic             sync_q;
  logic             pressed;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;

  // Synchronizer; resets to the released level so reset exit never looks like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= key_n_i;
      sync_q <= meta_q;
    end
  end

  assign pressed = ~sync_q;

  // FSM, counter and request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  // Next-state logic; the counter is cleared on every state change so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          req_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed returns to HELD without a new request.
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign req_o = req_q;

endmodule

// File: rtl/input_conditioner.sv
// Control-path front end: debounced one-cycle button commands and a
// stability-filtered algorithm switch selection with error flags.
// Ports:
//   clk, reset                  - system clock, asynchronous active-high reset
//   key_n[2:0]                  - raw active-low buttons (return, zoom_in, zoom_out)
//   sw[3:0]                     - raw algorithm switches
//   return/zoom_in/zoom_out_pulse - one-cycle commands, at most one high per cycle
//   algorithm_select[1:0]       - encoded stable switch selection
//   multiple_switches_error     - more than one stable switch high
//   no_switch_selected_error    - stable switch vector is zero
//   sw_changed                  - one-cycle pulse when the stable vector updates
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES  = 1000000,
  parameter int unsigned SW_STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W            = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [NUM_SW-1:0]   sw,
  output logic                return_pulse,
  output logic                zoom_in_pulse,
  output logic                zoom_out_pulse,
  output logic [ALG_W-1:0]    algorithm_select,
  output logic                multiple_switches_error,
  output logic                no_switch_selected_error,
  output logic                sw_changed
);

  localparam logic [CNT_W-1:0] SW_CNT_LAST = CNT_W'(SW_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_CNT_ONE  = CNT_W'(1);

  logic [NUM_KEYS-1:0] req;
  logic [NUM_KEYS-1:0] pulse_q, pulse_d;

  logic [NUM_SW-1:0]   sw_meta_q;
  logic [NUM_SW-1:0]   sw_sync_q;
  logic [NUM_SW-1:0]   cand_q, cand_d;
  logic [NUM_SW-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]    sw_cnt_q, sw_cnt_d;
  logic                changed_q, changed_d;
  logic [ALG_W-1:0]    alg_q, alg_d;
  logic                multi_q, multi_d;
  logic                none_q, none_d;

  // One debouncer per button.
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    debounce_fsm #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .key_n_i (key_n[k]),
      .req_o   (req[k])
    );
  end

  // Fixed-priority arbitration; losing requests are dropped.
  always_comb begin
    pulse_d = '0;
    if (req[KEY_RETURN])        pulse_d[KEY_RETURN]   = 1'b1;
    else if (req[KEY_ZOOM_IN])  pulse_d[KEY_ZOOM_IN]  = 1'b1;
    else if (req[KEY_ZOOM_OUT]) pulse_d[KEY_ZOOM_OUT] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pulse_q <= '0;
    else       pulse_q <= pulse_d;
  end

  // Switch synchronizer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
    end
  end

  // Switch stability filter. Outputs are decoded from stable_d so that they
  // move on the same edge as sw_changed.
  always_comb begin
    cand_d    = cand_q;
    sw_cnt_d  = sw_cnt_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (sw_sync_q != cand_q) begin
      cand_d   = sw_sync_q;
      sw_cnt_d = '0;
    end else if (sw_cnt_q != SW_CNT_LAST) begin
      sw_cnt_d = sw_cnt_q + SW_CNT_ONE;
    end else if (cand_q != stable_q) begin
      stable_d  = cand_q;
      changed_d = 1'b1;
    end
    alg_d   = encode_alg(stable_d);
    multi_d = multi_hot(stable_d);
    none_d  = (stable_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cand_q    <= '0;
      sw_cnt_q  <= '0;
      stable_q  <= '0;
      changed_q <= 1'b0;
      alg_q     <= ALG_0;
      multi_q   <= 1'b0;
      none_q    <= 1'b1;
    end else begin
      cand_q    <= cand_d;
      sw_cnt_q  <= sw_cnt_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      alg_q     <= alg_d;
      multi_q   <= multi_d;
      none_q    <= none_d;
    end
  end

  assign return_pulse             = pulse_q[KEY_RETURN];
  assign zoom_in_pulse            = pulse_q[KEY_ZOOM_IN];
  assign zoom_out_pulse           = pulse_q[KEY_ZOOM_OUT];
  assign algorithm_select         = alg_q;
  assign multiple_switches_error  = multi_q;
  assign no_switch_selected_error = none_q;
  assign sw_changed               = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner with short debounce windows.
module tb_input_conditioner;

  logic       clk;
  logic       reset;
  logic [2:0] key_n;
  logic [3:0] sw;
  logic       return_pulse;
  logic       zoom_in_pulse;
  logic       zoom_out_pulse;
  logic [1:0] algorithm_select;
  logic       multiple_switches_error;
  logic       no_switch_selected_error;
  logic       sw_changed;

  int checks = 0;
  int errors = 0;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .SW_STABLE_CYCLES (4),
    .CNT_W            (3)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .key_n                    (key_n),
    .sw                       (sw),
    .return_pulse             (return_pulse),
    .zoom_in_pulse            (zoom_in_pulse),
    .zoom_out_pulse           (zoom_out_pulse),
    .algorithm_select         (algorithm_select),
    .multiple_switches_error  (multiple_switches_error),
    .no_switch_selected_error (no_switch_selected_error),
    .sw_changed               (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic er, input logic ezi, input logic ezo);
    chk({tag, "_ret"},  {1'b0, return_pulse},   {1'b0, er});
    chk({tag, "_zin"},  {1'b0, zoom_in_pulse},  {1'b0, ezi});
    chk({tag, "_zout"}, {1'b0, zoom_out_pulse}, {1'b0, ezo});
  endtask

  task automatic chk_sw(input string tag, input logic [1:0] alg, input logic multi,
                        input logic none, input logic chg);
    chk({tag, "_alg"},   algorithm_select,                   alg);
    chk({tag, "_multi"}, {1'b0, multiple_switches_error},    {1'b0, multi});
    chk({tag, "_none"},  {1'b0, no_switch_selected_error},   {1'b0, none});
    chk({tag, "_chg"},   {1'b0, sw_changed},                 {1'b0, chg});
  endtask

  initial begin
    reset = 1'b1;
    key_n = 3'b111;
    sw    = 4'b0100;
    repeat (3) step();
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    chk_sw("rst", 2'b00, 1'b0, 1'b1, 1'b0);

    // Switch vector 0100 qualifies on the 7th edge after reset release.
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_pulses($sformatf("swinit%0d", i), 1'b0, 1'b0, 1'b0);
      chk_sw($sformatf("swinit%0d", i), (i >= 7) ? 2'b10 : 2'b00, 1'b0,
             (i < 7), (i == 7));
    end

    // Clean zoom-in press: single pulse on the 8th sample, none while held.
    key_n = 3'b101;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk_pulses($sformatf("clean%0d", i), 1'b0, (i == 8), 1'b0);
    end
    key_n = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_pulses($sformatf("clean_rel%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Short zoom-out press is filtered.
    key_n = 3'b011;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_pulses($sformatf("short%0d", i), 1'b0, 1'b0, 1'b0);
    end
    key_n = 3'b111;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_pulses($sformatf("short_rel%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Full zoom-out press, then a bouncy release.
    key_n = 3'b011;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_pulses($sformatf("long%0d", i), 1'b0, 1'b0, (i == 8));
    end
    key_n = 3'b111;
    for (int i = 1; i <= 2; i++) begin
      step();
      chk_pulses($sformatf("bounce_a%0d", i), 1'b0, 1'b0, 1'b0);
    end
    key_n = 3'b011;
    step();
    chk_pulses("bounce_b", 1'b0, 1'b0, 1'b0);
    key_n = 3'b111;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk_pulses($sformatf("bounce_c%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Return and zoom-in together: return wins, zoom-in dropped.
    key_n = 3'b100;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_pulses($sformatf("simul%0d", i), (i == 8), 1'b0, 1'b0);
    end
    key_n = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_pulses($sformatf("simul_rel%0d", i), 1'b0, 1'b0, 1'b0);
    end

    // Two switches high: multiple-switch error, lowest switch encoded.
    sw = 4'b0011;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_sw($sformatf("swmulti%0d", i), (i >= 7) ? 2'b00 : 2'b10, (i >= 7),
             1'b0, (i == 7));
    end

    // Switches toggling every 2 cycles never qualify.
    for (int i = 0; i < 16; i++) begin
      sw = (((i >> 1) & 1) == 0) ? 4'b1000 : 4'b0011;
      step();
      chk_sw($sformatf("swtog%0d", i), 2'b00, 1'b1, 1'b0, 1'b0);
    end
    sw = 4'b0011;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk_sw($sformatf("swsettle%0d", i), 2'b00, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of a zoom-out debounce.
    key_n = 3'b011;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk_pulses($sformatf("mid%0d", i), 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b1;
    #1;
    chk_pulses("mid_rst", 1'b0, 1'b0, 1'b0);
    chk_sw("mid_rst", 2'b00, 1'b0, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      chk_pulses($sformatf("mid_post%0d", i), 1'b0, 1'b0, (i == 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
